// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel front end.
// Imported by the frame controller, its bus interface and the position counter.
package sobel_pkg;

    localparam int DEFAULT_IMG_WIDTH  = 128;
    localparam int DEFAULT_IMG_HEIGHT = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PRIME,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Counter width for a dimension of n positions (0..n-1).
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Pixel handshake, line-buffer control and window-flag bundle of the frame controller.
// master is the surrounding pipeline; slave is sobel_frame_ctrl.
interface sobel_frame_ctrl_if #(
    parameter int IMG_WIDTH  = sobel_pkg::DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = sobel_pkg::DEFAULT_IMG_HEIGHT
);
    localparam int CW = sobel_pkg::cnt_width(IMG_WIDTH);
    localparam int RW = sobel_pkg::cnt_width(IMG_HEIGHT);

    logic          s_valid;
    logic          s_ready;
    logic          lb_valid_in;
    logic          lb_clear;
    logic          m_ready;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_sof;
    logic          win_eol;
    logic          win_eof;

    modport master (
        output s_valid, m_ready,
        input  s_ready, lb_valid_in, lb_clear,
        input  win_valid, win_row, win_col, win_sof, win_eol, win_eof
    );

    modport slave (
        input  s_valid, m_ready,
        output s_ready, lb_valid_in, lb_clear,
        output win_valid, win_row, win_col, win_sof, win_eol, win_eof
    );

endinterface

// File: rtl/sobel_pos_counter.sv
// Raster column/row counter with wrap and end-of-row / end-of-frame flags.
// Advances only when told to, so stalls simply hold the position.
module sobel_pos_counter
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int CW     = cnt_width(WIDTH),
    parameter int RW     = cnt_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_row
);

    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));

    // Row wraps with the final column so the next frame starts at the origin.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel front end: clears and primes the line buffer,
// then streams pixels and flags the ones that complete a 3x3 window.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        frame_cnt,
    sobel_frame_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    state_t        state;
    state_t        next_state;
    logic          s_ready_int;
    logic          accept;
    logic          lb_clear_q;
    logic          win_valid;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_row;

    sobel_pos_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .CW     (CW),
        .RW     (RW)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_CLEAR),
        .advance  (accept),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start) next_state = ST_CLEAR;
            ST_CLEAR:  next_state = ST_PRIME;
            ST_PRIME:  if (accept && last_col && (row == RW'(1))) next_state = ST_STREAM;
            ST_STREAM: if (accept && last_col && last_row) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Priming rows emit no windows, so only STREAM is throttled by the consumer.
    always_comb begin
        busy        = 1'b1;
        done        = 1'b0;
        s_ready_int = 1'b0;
        unique case (state)
            ST_IDLE:   busy = 1'b0;
            ST_PRIME:  s_ready_int = 1'b1;
            ST_STREAM: s_ready_int = bus.m_ready;
            ST_DONE:   done = 1'b1;
            default:   s_ready_int = 1'b0;
        endcase
    end

    // lb_clear is registered so the buffer stays cleared while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_clear_q <= 1'b1;
            frame_cnt  <= '0;
        end else begin
            lb_clear_q <= (next_state == ST_CLEAR);
            if (state == ST_DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign accept    = bus.s_valid & s_ready_int;
    assign win_valid = accept & (state == ST_STREAM) & (col >= CW'(2));

    assign bus.s_ready     = s_ready_int;
    assign bus.lb_valid_in = accept;
    assign bus.lb_clear    = lb_clear_q;

    // Window centre is one row and one column behind the incoming pixel.
    assign bus.win_valid = win_valid;
    assign bus.win_row   = win_valid ? row - RW'(1) : '0;
    assign bus.win_col   = win_valid ? col - CW'(1) : '0;
    assign bus.win_sof   = win_valid & (row == RW'(2)) & (col == CW'(2));
    assign bus.win_eol   = win_valid & last_col;
    assign bus.win_eof   = win_valid & last_col & last_row;

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer for the Sobel front end. It accepts one frame of raster pixels per `start` command and drives the line buffer's shift enable and clear. It also tracks row/column position and flags which accepted pixels complete a valid 3x3 window, with SOF/EOL/EOF markers for the downstream window/gradient stage. Output backpressure is propagated upstream.

Parameters:
- IMG_WIDTH, 128: pixels per row; must be >= 3.
- IMG_HEIGHT, 128: rows per frame; must be >= 3.
- CW, $clog2(IMG_WIDTH): column counter width (localparam).
- RW, $clog2(IMG_HEIGHT): row counter width (localparam).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset. One clock; reset is synchronous and active-high.
- start, in, 1: begin-frame pulse; honoured only in IDLE.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse after the last pixel of a frame.
- s_valid, in, 1: upstream pixel valid.
- s_ready, out, 1: upstream ready (combinational).
- lb_valid_in, out, 1: line buffer shift enable; equals accept = s_valid & s_ready.
- lb_clear, out, 1: line buffer clear; drive the buffer's active-low reset with ~lb_clear.
- m_ready, in, 1: downstream window stage ready.
- win_valid, out, 1: the accepted pixel completes a 3x3 window.
- win_row, out, RW: row of the window centre (row-1).
- win_col, out, CW: column of the window centre (col-1).
- win_sof, out, 1: first window of the frame.
- win_eol, out, 1: last window of the row.
- win_eof, out, 1: last window of the frame.
- frame_cnt, out, 16: count of completed frames; wraps.

Behaviour:
- Reset values:
  - state = IDLE; col = 0; row = 0; frame_cnt = 0.
  - busy = 0; done = 0.
  - lb_clear = 1 (registered, so the buffer is held cleared during reset).
  - All win_* outputs are 0 because accept = 0.
- FSM states: IDLE, CLEAR, PRIME, STREAM, DONE.
  - IDLE: s_ready = 0, lb_clear = 0. start -> CLEAR.
  - CLEAR: exactly 1 cycle. lb_clear = 1, s_ready = 0. Counters zeroed. -> PRIME.
  - PRIME: rows 0..1. s_ready = 1 (no window output, so no backpressure). On accept with col == W-1 && row == 1 -> STREAM.
  - STREAM: rows 2..H-1. s_ready = m_ready. On accept with row == H-1 && col == W-1 -> DONE.
  - DONE: 1 cycle. done = 1, frame_cnt += 1. -> IDLE.
- Counters advance only on accept:
  - col wraps W-1 -> 0.
  - row increments on col wrap.
- Window outputs are combinational, same cycle as accept. Zero latency is required because the line buffer taps are combinational on din.
  - win_valid = accept & (state == STREAM) & (col >= 2).
  - win_row = row-1; win_col = col-1.
  - win_sof = win_valid & row == 2 & col == 2.
  - win_eol = win_valid & col == W-1.
  - win_eof = win_eol & row == H-1.
- Windows per frame: (W-2)*(H-2). Columns 0..1 of each STREAM row are accepted (they fill the line buffer) but flag no window.
- start while busy: ignored, with no effect on the counters or the frame.
- s_valid outside PRIME/STREAM: not accepted, lb_valid_in = 0.
- m_ready low in STREAM:
  - s_ready = 0, so there are no accepts and counters and lb_valid_in hold.
  - No data is dropped and no duplicate window is emitted.
- rst mid-frame: next cycle is IDLE with counters 0 and lb_clear = 1. The next start re-clears the buffer, so no stale rows are used.
- start in the same cycle as rst: rst wins.
- frame_cnt wraps 0xFFFF -> 0.

Decomposition:
- Shared package sobel_pkg holds:
  - the state enum;
  - IMG_WIDTH/IMG_HEIGHT defaults;
  - the CW/RW width helpers.
- One natural sub-module: sobel_pos_counter (col/row counter with wrap and last-pixel flags), reusable by the later gradient stage.
- FSM and flag decode stay in sobel_frame_ctrl.

Test Plan:
- Bench uses W = 8, H = 6.
- Frame with s_valid = 1, m_ready = 1:
  - Response: exactly 48 accepts and 24 win_valid.
  - win_sof at (row 1, col 1); win_eof at (row 4, col 6).
  - done one cycle after the last accept; frame_cnt = 1.
- CLEAR timing: start -> lb_clear high for exactly 1 cycle, followed by PRIME. During the 16 PRIME accepts there are no win_valid, even with m_ready = 0.
- Backpressure: m_ready toggling 1/0 every cycle in STREAM.
  - Still 24 windows, in raster order, with no duplicates.
  - s_ready mirrors m_ready; lb_valid_in is low on stall cycles.
- start pulsed in PRIME: no effect; frame completes normally with 24 windows.
- rst asserted after 30 accepts:
  - Next cycle busy = 0, lb_clear = 1.
  - A new start gives a clean frame of 24 windows.
- 2 back-to-back frames: frame_cnt = 2, and win_sof fires once per frame.
